keypad_scan_encoder: RTL and testbench
======================================

# keypad_scan_encoder

Scans a 4x4 matrix keypad and encodes one debounced key press into a 4-bit code with a one-cycle valid strobe. It is the input end of the lab board's count/display path: the display side decodes binary to segments, and this block encodes physical key contacts to binary. Its output feeds counter preload and control logic.

## Interface
Parameters:
- SCAN_DIV, 16'd50000: clock cycles per column dwell. Must be ≥ 4.
- DEBOUNCE_SCANS, 4'd4: consecutive matching samples required to accept a press or a release. Must be ≥ 2.

Ports:
- clock_in  input  1  system clock; the block uses one clock only
- Rst  input  1  reset; asynchronous, active-low
- ROW  input  4  keypad rows; active-low with external pull-ups; asynchronous to clock_in
- COL  output  4  column drive; active-low, exactly one bit low
- KEY  output  4  code {row_idx[1:0], col_idx[1:0]} of the last accepted key
- VALID  output  1  one-cycle pulse when KEY is updated
- HELD  output  1  high from an accepted press until its release is debounced

## Operation
- ROW passes through a 2-flop synchronizer (rs). All decisions use rs.
- Prescaler counts 0..SCAN_DIV-1 and wraps. tick = (prescaler == SCAN_DIV-1). Samples are taken only on tick.
- Single press in the current column: rs has exactly one bit low. Release: rs == 4'hF. Any other pattern is multi-key and is treated as no press.
- States:
  - SCAN: at tick, on a single press, latch the pattern, set dbcnt = 1, go to DEBOUNCE, and hold COL. Otherwise rotate COL.
  - DEBOUNCE: at tick, if rs equals the latched pattern, dbcnt++. When dbcnt reaches DEBOUNCE_SCANS, go to PRESSED and load KEY. On a mismatch, go to SCAN and rotate COL.
  - PRESSED: HELD = 1 and COL is held. At tick, if rs == 4'hF, set dbcnt = 1 and go to RELEASE. Any other pattern stays in PRESSED, with no new VALID.
  - RELEASE: at tick, if rs == 4'hF, dbcnt++. When dbcnt reaches DEBOUNCE_SCANS, go to SCAN, clear HELD and rotate COL. If any row is low, return to PRESSED with no new VALID.
- Column rotation: 1110 → 1101 → 1011 → 0111 → 1110. col_idx = position of the low bit.
- row_idx = position of the low bit in the latched pattern. KEY holds its value until the next accepted press.
- Reset (Rst = 0, at any time, including mid-debounce): state SCAN, COL = 4'b1110, KEY = 4'h0, VALID = 0, HELD = 0, prescaler = 0, dbcnt = 0, synchronizer = 4'hF. On release of Rst, operation resumes from column 0.

## Timing
- All outputs are registered.
- COL changes in the cycle after the tick that decides a rotation. Rows therefore have SCAN_DIV-1 cycles to settle.
- ROW to rs latency is 2 cycles. Edges closer than 2 cycles to a tick may or may not be seen on that tick.
- Press: VALID and the new KEY appear in the cycle after the tick where dbcnt reaches DEBOUNCE_SCANS. This is (DEBOUNCE_SCANS-1)*SCAN_DIV+1 cycles after the first-detect tick.
- VALID is high for exactly 1 cycle per accepted press. It is never asserted while HELD is already 1.
- HELD rises together with VALID. HELD falls in the cycle after the tick that completes release debounce.
- A bounce that breaks either run restarts that run. It never produces extra VALID pulses.

## Structure
- Shared include file keypad_defs.vh holds:
  - state encodings KP_SCAN = 2'd0, KP_DEBOUNCE = 2'd1, KP_PRESSED = 2'd2, KP_RELEASE = 2'd3
  - COL reset constant 4'b1110
  - defaults for SCAN_DIV and DEBOUNCE_SCANS
- Sub-module: sync2 (4-bit, 2-flop synchronizer, async active-low reset to all ones).
- Prescaler, FSM and encoder stay in the top-level module.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 3.
- Reset: assert Rst = 0 mid-DEBOUNCE → immediately COL = 1110, KEY = 0, VALID = 0, HELD = 0. After Rst = 1, COL steps every 4 cycles: 1110 → 1101 → 1011 → 0111 → 1110.
- Clean press: the model pulls ROW[2] low whenever COL = 1101 → exactly one VALID with KEY = 4'b1001 (row 2, col 1), 9 cycles after the first-detect tick. HELD = 1 and COL is frozen at 1101.
- Release: from the clean-press state, raise ROW → HELD clears after 3 all-high ticks, no VALID, and rotation resumes from 1011.
- Bounce: during DEBOUNCE, ROW toggles high for one tick → no VALID and rotation resumes. A later stable press of the same key → one VALID.
- Multi-key: ROW = 4'b0101 in column 3 → ignored, no VALID, rotation continues. Hold key (0,3) alone → KEY = 4'b0011.
- Release bounce: in RELEASE, the row goes low again after 1 high tick → back to PRESSED, HELD stays 1, no second VALID.

Source files
------------

// File: rtl/keypad_scan_encoder_pkg.sv
// Shared definitions for the keypad scanner: FSM state encodings, column reset
// pattern, parameter defaults and small pattern-decoding helpers.
`timescale 1ns/1ps
package keypad_scan_encoder_pkg;

  typedef enum logic [1:0] {
    KP_SCAN     = 2'd0,
    KP_DEBOUNCE = 2'd1,
    KP_PRESSED  = 2'd2,
    KP_RELEASE  = 2'd3
  } kp_state_e;

  localparam logic [3:0]  KP_COL_RESET        = 4'b1110;
  localparam logic [3:0]  KP_ALL_HIGH         = 4'hF;
  localparam logic [15:0] KP_SCAN_DIV_DEFAULT = 16'd50000;
  localparam logic [3:0]  KP_DEBOUNCE_DEFAULT = 4'd4;

  // True when exactly one line of an active-low 4-bit pattern is pulled low.
  function automatic logic kpIsSingle(input logic [3:0] pattern);
    logic single;
    case (pattern)
      4'b1110, 4'b1101, 4'b1011, 4'b0111: single = 1'b1;
      default:                            single = 1'b0;
    endcase
    return single;
  endfunction

  function automatic logic [1:0] kpLowIdx(input logic [3:0] pattern);
    logic [1:0] idx;
    case (pattern)
      4'b1101: idx = 2'd1;
      4'b1011: idx = 2'd2;
      4'b0111: idx = 2'd3;
      default: idx = 2'd0;
    endcase
    return idx;
  endfunction

  function automatic logic [3:0] kpRotate(input logic [3:0] col);
    return {col[2:0], col[3]};
  endfunction

endpackage

// File: rtl/keypad_scan_encoder_sync2.sv
// Two-flop synchronizer for the four keypad row inputs; resets to all ones so
// an idle keypad (no rows pulled low) is seen during and right after reset.
`timescale 1ns/1ps
module keypad_scan_encoder_sync2
  import keypad_scan_encoder_pkg::*;
(
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic [3:0] i_d,
  output logic [3:0] o_q
);

  logic [3:0] r_meta;
  logic [3:0] r_sync;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_meta <= KP_ALL_HIGH;
      r_sync <= KP_ALL_HIGH;
    end else begin
      r_meta <= i_d;
      r_sync <= r_meta;
    end
  end

  assign o_q = r_sync;

endmodule

// File: rtl/keypad_scan_encoder.sv
// 4x4 matrix keypad scanner: rotates an active-low column drive, debounces a
// single-key press and its release, and emits the key code with a valid strobe.
`timescale 1ns/1ps
module keypad_scan_encoder
  import keypad_scan_encoder_pkg::*;
#(
  parameter logic [15:0] SCAN_DIV       = KP_SCAN_DIV_DEFAULT,
  parameter logic [3:0]  DEBOUNCE_SCANS = KP_DEBOUNCE_DEFAULT
) (
  input  logic       clock_in,
  input  logic       Rst,
  input  logic [3:0] ROW,
  output logic [3:0] COL,
  output logic [3:0] KEY,
  output logic       VALID,
  output logic       HELD
);

  logic [15:0] r_presc;
  logic [3:0]  r_col;
  logic [3:0]  r_key;
  logic        r_valid;
  logic        r_held;
  logic [3:0]  r_dbCnt;
  logic [3:0]  r_pattern;
  kp_state_e   r_state;

  logic [3:0]  w_rs;
  logic        w_tick;
  logic        w_single;
  logic        w_allHigh;
  logic        w_match;
  logic [3:0]  w_dbInc;
  logic        w_dbDone;
  kp_state_e   w_nextState;
  logic [3:0]  w_colNext;
  logic [3:0]  w_keyNext;
  logic        w_validNext;
  logic        w_heldNext;
  logic [3:0]  w_dbCntNext;
  logic [3:0]  w_patternNext;

  keypad_scan_encoder_sync2 u_sync (
    .i_clk   (clock_in),
    .i_rst_n (Rst),
    .i_d     (ROW),
    .o_q     (w_rs)
  );

  assign w_tick    = (r_presc == (SCAN_DIV - 16'd1));
  assign w_single  = kpIsSingle(w_rs);
  assign w_allHigh = (w_rs == KP_ALL_HIGH);
  assign w_match   = (w_rs == r_pattern);
  assign w_dbInc   = r_dbCnt + 4'd1;
  assign w_dbDone  = (w_dbInc == DEBOUNCE_SCANS);

  always_ff @(posedge clock_in or negedge Rst) begin
    if (!Rst) begin
      r_presc <= 16'd0;
    end else if (w_tick) begin
      r_presc <= 16'd0;
    end else begin
      r_presc <= r_presc + 16'd1;
    end
  end

  always_ff @(posedge clock_in or negedge Rst) begin
    if (!Rst) begin
      r_state <= KP_SCAN;
    end else begin
      r_state <= w_nextState;
    end
  end

  always_comb begin
    w_nextState = r_state;
    if (w_tick) begin
      case (r_state)
        KP_SCAN: begin
          if (w_single) w_nextState = KP_DEBOUNCE;
        end
        KP_DEBOUNCE: begin
          if (!w_match)      w_nextState = KP_SCAN;
          else if (w_dbDone) w_nextState = KP_PRESSED;
        end
        KP_PRESSED: begin
          if (w_allHigh) w_nextState = KP_RELEASE;
        end
        KP_RELEASE: begin
          if (!w_allHigh)    w_nextState = KP_PRESSED;
          else if (w_dbDone) w_nextState = KP_SCAN;
        end
        default: w_nextState = KP_SCAN;
      endcase
    end
  end

  // Column is frozen from first detect until release completes, so the
  // column index of the key is simply the position of the low COL bit.
  always_comb begin
    w_colNext     = r_col;
    w_keyNext     = r_key;
    w_validNext   = 1'b0;
    w_heldNext    = r_held;
    w_dbCntNext   = r_dbCnt;
    w_patternNext = r_pattern;
    if (w_tick) begin
      case (r_state)
        KP_SCAN: begin
          if (w_single) begin
            w_patternNext = w_rs;
            w_dbCntNext   = 4'd1;
          end else begin
            w_colNext = kpRotate(r_col);
          end
        end
        KP_DEBOUNCE: begin
          if (!w_match) begin
            w_dbCntNext = 4'd0;
            w_colNext   = kpRotate(r_col);
          end else begin
            w_dbCntNext = w_dbInc;
            if (w_dbDone) begin
              w_keyNext   = {kpLowIdx(r_pattern), kpLowIdx(r_col)};
              w_validNext = 1'b1;
              w_heldNext  = 1'b1;
            end
          end
        end
        KP_PRESSED: begin
          if (w_allHigh) w_dbCntNext = 4'd1;
        end
        KP_RELEASE: begin
          if (!w_allHigh) begin
            w_dbCntNext = 4'd0;
          end else if (w_dbDone) begin
            w_dbCntNext = 4'd0;
            w_heldNext  = 1'b0;
            w_colNext   = kpRotate(r_col);
          end else begin
            w_dbCntNext = w_dbInc;
          end
        end
        default: begin
          w_dbCntNext = 4'd0;
        end
      endcase
    end
  end

  always_ff @(posedge clock_in or negedge Rst) begin
    if (!Rst) begin
      r_col     <= KP_COL_RESET;
      r_key     <= 4'h0;
      r_valid   <= 1'b0;
      r_held    <= 1'b0;
      r_dbCnt   <= 4'd0;
      r_pattern <= KP_ALL_HIGH;
    end else begin
      r_col     <= w_colNext;
      r_key     <= w_keyNext;
      r_valid   <= w_validNext;
      r_held    <= w_heldNext;
      r_dbCnt   <= w_dbCntNext;
      r_pattern <= w_patternNext;
    end
  end

  assign COL   = r_col;
  assign KEY   = r_key;
  assign VALID = r_valid;
  assign HELD  = r_held;

endmodule

// File: tb/tb_keypad_scan_encoder.sv
// Directed bench for keypad_scan_encoder: a keypad matrix model drives ROW from
// COL, accepted key codes are checked against a queue of expected presses.
`timescale 1ns/1ps
module tb_keypad_scan_encoder;

  logic       clock_in;
  logic       Rst;
  logic [3:0] ROW;
  logic [3:0] COL;
  logic [3:0] KEY;
  logic       VALID;
  logic       HELD;

  logic [3:0] keyDown [4];
  logic [3:0] expQ[$];
  logic [3:0] seenQ[$];
  int         checks;
  int         errors;
  int         badValid;
  logic       prevHeld;

  keypad_scan_encoder #(
    .SCAN_DIV       (16'd4),
    .DEBOUNCE_SCANS (4'd3)
  ) dut (
    .clock_in (clock_in),
    .Rst      (Rst),
    .ROW      (ROW),
    .COL      (COL),
    .KEY      (KEY),
    .VALID    (VALID),
    .HELD     (HELD)
  );

  initial begin
    clock_in = 1'b0;
    forever #5 clock_in = ~clock_in;
  end

  // A row reads low when a pressed key in that row sits in the driven column.
  always_comb begin
    ROW = 4'hF;
    for (int r = 0; r < 4; r++) begin
      ROW[r] = ~|(keyDown[r] & ~COL);
    end
  end

  // Capture every strobed key code and flag any strobe while already held.
  initial begin
    badValid = 0;
    prevHeld = 1'b0;
    forever begin
      @(negedge clock_in);
      if (Rst && VALID) begin
        seenQ.push_back(KEY);
        if (prevHeld) badValid++;
      end
      prevHeld = Rst ? HELD : 1'b0;
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input int row, input int col, input logic pressed);
    keyDown[row][col] = pressed;
  endtask

  task automatic waitCycles(input int n);
    repeat (n) @(negedge clock_in);
  endtask

  task automatic checkReset(input string phase);
    checkOutput({phase, "_col"},   COL,   4'b1110);
    checkOutput({phase, "_key"},   KEY,   4'h0);
    checkOutput({phase, "_valid"}, VALID, 1'b0);
    checkOutput({phase, "_held"},  HELD,  1'b0);
  endtask

  initial begin
    logic [3:0] colExp;
    checks = 0;
    errors = 0;
    for (int r = 0; r < 4; r++) keyDown[r] = 4'h0;
    Rst = 1'b0;

    // Power-on reset, then free rotation with no keys; cycle k counts from release.
    waitCycles(2);
    checkReset("por");
    Rst = 1'b1;
    for (int k = 1; k <= 16; k++) begin
      waitCycles(1);
      colExp = 4'hF & ~(4'b0001 << ((k / 4) % 4));
      checkOutput($sformatf("rot_k%0d", k), COL, colExp);
    end

    // Key (2,1): first detect at tick 24, then reset in the middle of debounce.
    applyStimulus(2, 1, 1'b1);
    waitCycles(10);
    checkOutput("dbn_col_k26", COL, 4'b1101);
    waitCycles(3);
    checkOutput("dbn_col_k29", COL, 4'b1101);
    checkOutput("dbn_held_k29", HELD, 1'b0);
    Rst = 1'b0;
    #1;
    checkReset("mid_dbn");
    checkOutput("mid_dbn_novalid", seenQ.size(), 0);

    // Clean press of (2,1) from a fresh start: detect at tick 8, VALID at k=16.
    waitCycles(1);
    Rst = 1'b1;
    expQ.push_back(4'b1001);
    waitCycles(15);
    checkOutput("press_valid_k15", VALID, 1'b0);
    waitCycles(1);
    checkOutput("press_valid_k16", VALID, 1'b1);
    checkOutput("press_key_k16", KEY, 4'b1001);
    checkOutput("press_held_k16", HELD, 1'b1);
    waitCycles(1);
    checkOutput("press_valid_k17", VALID, 1'b0);
    checkOutput("press_held_k17", HELD, 1'b1);
    waitCycles(7);
    checkOutput("press_col_k24", COL, 4'b1101);

    // Release: high ticks 28/32/36, HELD drops and rotation resumes at 1011.
    applyStimulus(2, 1, 1'b0);
    waitCycles(11);
    checkOutput("rel_held_k35", HELD, 1'b1);
    checkOutput("rel_col_k35", COL, 4'b1101);
    waitCycles(1);
    checkOutput("rel_held_k36", HELD, 1'b0);
    checkOutput("rel_col_k36", COL, 4'b1011);
    checkOutput("rel_valid_k36", VALID, 1'b0);
    waitCycles(4);
    checkOutput("rel_col_k40", COL, 4'b0111);

    // Bounce on key (1,1): detect at tick 52, one high tick at 56 aborts.
    applyStimulus(1, 1, 1'b1);
    waitCycles(13);
    checkOutput("bnc_col_k53", COL, 4'b1101);
    applyStimulus(1, 1, 1'b0);
    waitCycles(3);
    checkOutput("bnc_col_k56", COL, 4'b1011);
    checkOutput("bnc_held_k56", HELD, 1'b0);
    waitCycles(1);
    applyStimulus(1, 1, 1'b1);
    expQ.push_back(4'b0101);
    waitCycles(22);
    checkOutput("bnc_valid_k79", VALID, 1'b0);
    waitCycles(1);
    checkOutput("bnc_valid_k80", VALID, 1'b1);
    checkOutput("bnc_key_k80", KEY, 4'b0101);
    checkOutput("bnc_held_k80", HELD, 1'b1);

    // Release bounce: high at tick 84, low again at 88, final release at 92..100.
    applyStimulus(1, 1, 1'b0);
    waitCycles(5);
    applyStimulus(1, 1, 1'b1);
    checkOutput("rbnc_held_k85", HELD, 1'b1);
    waitCycles(4);
    checkOutput("rbnc_held_k89", HELD, 1'b1);
    checkOutput("rbnc_col_k89", COL, 4'b1101);
    applyStimulus(1, 1, 1'b0);
    waitCycles(10);
    checkOutput("rbnc_held_k99", HELD, 1'b1);
    waitCycles(1);
    checkOutput("rbnc_held_k100", HELD, 1'b0);
    checkOutput("rbnc_col_k100", COL, 4'b1011);

    // Multi-key rows 1 and 3 in column 3 are ignored; then key (0,3) alone.
    applyStimulus(1, 3, 1'b1);
    applyStimulus(3, 3, 1'b1);
    waitCycles(8);
    checkOutput("multi_col_k108", COL, 4'b1110);
    waitCycles(4);
    checkOutput("multi_col_k112", COL, 4'b1101);
    applyStimulus(1, 3, 1'b0);
    applyStimulus(3, 3, 1'b0);
    applyStimulus(0, 3, 1'b1);
    expQ.push_back(4'b0011);
    waitCycles(19);
    checkOutput("single_valid_k131", VALID, 1'b0);
    waitCycles(1);
    checkOutput("single_valid_k132", VALID, 1'b1);
    checkOutput("single_key_k132", KEY, 4'b0011);
    checkOutput("single_held_k132", HELD, 1'b1);
    waitCycles(4);

    // Scoreboard drain: every accepted key must match the expected press order.
    checkOutput("valid_count", seenQ.size(), expQ.size());
    for (int i = 0; i < expQ.size(); i++) begin
      if (i < seenQ.size()) checkOutput($sformatf("sb_key_%0d", i), seenQ[i], expQ[i]);
    end
    checkOutput("valid_while_held", badValid, 0);

    $display("[TB] scenarios complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
